// File: rtl/cpu_seq.sv
// Fetch/decode/execute sequencer for the 8-bit-opcode accumulator machine on a shared tri-state bus.
// It issues one bus driver per cycle plus all load strobes, and uses a bounded memory-ready handshake.
module cpu_seq #(
   parameter logic [7:0] OP_NOP      = 8'h00,
   parameter logic [7:0] OP_LDA      = 8'h01,
   parameter logic [7:0] OP_STA      = 8'h02,
   parameter logic [7:0] OP_ADD      = 8'h03,
   parameter logic [7:0] OP_JMP      = 8'h04,
   parameter logic [7:0] OP_JZ       = 8'h05,
   parameter logic [7:0] OP_HLT      = 8'hFF,
   parameter int         MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [7:0] ir_op,
   input  logic       acc_zero,
   input  logic       mem_ready,
   output logic       pc_valid,
   output logic       mem_valid,
   output logic       ir_valid,
   output logic       acc_valid,
   output logic       mar_load,
   output logic       ir_load,
   output logic       acc_load,
   output logic       alu_add,
   output logic       pc_load,
   output logic       pc_inc,
   output logic       mem_write,
   output logic       halted,
   output logic       bus_err,
   output logic [2:0] state
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_DEC  = 3'd3,
      S_EA   = 3'd4,
      S_MEM  = 3'd5,
      S_JP   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   state_t           st;
   logic [CNT_W-1:0] wait_cnt;
   logic             op_sta;
   logic             op_lda;
   logic             op_add;

   assign op_sta = (ir_op == OP_STA);
   assign op_lda = (ir_op == OP_LDA);
   assign op_add = (ir_op == OP_ADD);

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         case (st)
            S_IDLE: if (run) st <= S_F1;
            S_F1: begin
               st       <= S_F2;
               wait_cnt <= '0;
            end
            S_F2: begin
               if (mem_ready) begin
                  st <= S_DEC;
               end else if (wait_cnt == CNT_LAST) begin
                  st      <= S_HALT;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DEC: begin
               case (ir_op)
                  OP_NOP:                 st <= S_F1;
                  OP_LDA, OP_STA, OP_ADD: st <= S_EA;
                  OP_JMP:                 st <= S_JP;
                  OP_JZ:                  st <= acc_zero ? S_JP : S_F1;
                  OP_HLT:                 st <= S_HALT;
                  default:                st <= S_F1;
               endcase
            end
            S_EA: begin
               st       <= S_MEM;
               wait_cnt <= '0;
            end
            S_MEM: begin
               if (mem_ready) begin
                  st <= S_F1;
               end else if (wait_cnt == CNT_LAST) begin
                  st      <= S_HALT;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_JP:    st <= S_F1;
            S_HALT:  st <= S_HALT;
            default: st <= S_IDLE;
         endcase
      end
   end

   // Enables decode the current state; only the ready-qualified strobes look at mem_ready.
   always_comb begin
      pc_valid  = (st == S_F1);
      mar_load  = (st == S_F1) || (st == S_EA);
      mem_valid = (st == S_F2) || ((st == S_MEM) && !op_sta);
      ir_valid  = (st == S_EA) || (st == S_JP);
      pc_load   = (st == S_JP);
      acc_valid = (st == S_MEM) && op_sta;
      mem_write = (st == S_MEM) && op_sta;
      ir_load   = (st == S_F2) && mem_ready;
      pc_inc    = (st == S_F2) && mem_ready;
      acc_load  = (st == S_MEM) && (op_lda || op_add) && mem_ready;
      alu_add   = (st == S_MEM) && op_add && mem_ready;
      halted    = (st == S_HALT);
      state     = st;
   end

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: builds the expected per-cycle enable trace from instruction-level rules
// (fetch, decode, execute with chosen ready delays) and compares it cycle by cycle.
module tb_cpu_seq;

   localparam int T = 16;

   localparam logic [11:0] PCV  = 12'h800, MEMV = 12'h400, IRV  = 12'h200, ACCV = 12'h100;
   localparam logic [11:0] MAR  = 12'h080, IRL  = 12'h040, ACCL = 12'h020, ALU  = 12'h010;
   localparam logic [11:0] PCL  = 12'h008, PCI  = 12'h004, MW   = 12'h002, HLTD = 12'h001;

   logic       clk = 1'b0;
   logic       rst = 1'b1, run = 1'b0, acc_zero = 1'b0, mem_ready = 1'b0;
   logic [7:0] ir_op = 8'h00;
   logic       pc_valid, mem_valid, ir_valid, acc_valid, mar_load, ir_load, acc_load;
   logic       alu_add, pc_load, pc_inc, mem_write, halted, bus_err;
   logic [2:0] state;

   cpu_seq dut (
      .clk(clk), .rst(rst), .run(run), .ir_op(ir_op), .acc_zero(acc_zero), .mem_ready(mem_ready),
      .pc_valid(pc_valid), .mem_valid(mem_valid), .ir_valid(ir_valid), .acc_valid(acc_valid),
      .mar_load(mar_load), .ir_load(ir_load), .acc_load(acc_load), .alu_add(alu_add),
      .pc_load(pc_load), .pc_inc(pc_inc), .mem_write(mem_write), .halted(halted),
      .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   wire [11:0] obs = {pc_valid, mem_valid, ir_valid, acc_valid, mar_load, ir_load,
                      acc_load, alu_add, pc_load, pc_inc, mem_write, halted};

   typedef struct {
      logic        rdy;
      logic        run;
      logic [7:0]  op;
      logic        az;
      logic [11:0] ev;
      logic        err;
   } cyc_t;

   cyc_t q[$];
   int   checks = 0;
   int   failures = 0;
   bit   m_halt = 0;
   bit   m_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rdy, input logic [7:0] op, input logic az, input logic [11:0] ev);
      cyc_t c;
      c.rdy = rdy; c.run = rb(); c.op = op; c.az = az; c.ev = ev; c.err = m_err;
      q.push_back(c);
   endtask

   // IDLE cycle with run asserted: outputs all low, machine leaves IDLE next edge.
   task automatic start();
      push(rb(), 8'h00, 1'b0, 12'h000);
      q[$].run = 1'b1;
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) push(rb(), 8'($urandom), rb(), HLTD);
   endtask

   task automatic access(input int d, input logic [7:0] op, input logic az,
                         input logic [11:0] wv, input logic [11:0] dv, output bit to);
      to = 0;
      if (d >= T) begin
         for (int i = 0; i < T; i++) push(1'b0, op, az, wv);
         m_err = 1; m_halt = 1; to = 1;
         halt_cycles(4);
      end else begin
         for (int i = 0; i < d; i++) push(1'b0, op, az, wv);
         push(1'b1, op, az, dv);
      end
   endtask

   task automatic instr(input logic [7:0] op, input logic az, input int df, input int dm);
      bit to;
      logic [11:0] wv, dv;
      if (m_halt) return;
      push(rb(), op, az, PCV | MAR);
      access(df, op, az, MEMV, MEMV | IRL | PCI, to);
      if (to) return;
      push(rb(), op, az, 12'h000);
      case (op)
         8'h01, 8'h02, 8'h03: begin
            push(rb(), op, az, IRV | MAR);
            wv = (op == 8'h02) ? (ACCV | MW) : MEMV;
            dv = (op == 8'h02) ? (ACCV | MW) : (op == 8'h03) ? (MEMV | ACCL | ALU) : (MEMV | ACCL);
            access(dm, op, az, wv, dv, to);
         end
         8'h04: push(rb(), op, az, IRV | PCL);
         8'h05: if (az) push(rb(), op, az, IRV | PCL);
         8'hFF: begin
            m_halt = 1;
            halt_cycles(4);
         end
         default: ;
      endcase
   endtask

   task automatic play();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk); #1;
         mem_ready = c.rdy; run = c.run; ir_op = c.op; acc_zero = c.az;
         @(negedge clk);
         check("outs", 32'(obs), 32'(c.ev));
         check("bus_err", 32'(bus_err), 32'(c.err));
         check("one_driver", 32'($countones({pc_valid, mem_valid, ir_valid, acc_valid}) <= 1), 32'd1);
         check("mw_needs_acc", 32'(mem_write & ~acc_valid), 32'd0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b0; run = rb();
      @(posedge clk); #1;
      rst = 1'b0; run = 1'b0;
      @(negedge clk);
      check("rst_outs", 32'(obs), 32'd0);
      check("rst_err", 32'(bus_err), 32'd0);
      m_halt = 0; m_err = 0;
   endtask

   function automatic logic [7:0] rand_op();
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) return 8'(8'h06 + $urandom_range(0, 200));
      return 8'(k);
   endfunction

   function automatic int rand_wait();
      return ($urandom_range(0, 9) == 0) ? $urandom_range(4, T - 1) : $urandom_range(0, 2);
   endfunction

   initial begin
      do_reset();

      // idle with run low, then a NOP loop
      push(rb(), 8'h00, 1'b0, 12'h000); q[$].run = 1'b0;
      push(rb(), 8'h00, 1'b0, 12'h000); q[$].run = 1'b0;
      start();
      for (int i = 0; i < 3; i++) instr(8'h00, 1'b0, 0, 0);
      play();

      // directed instruction mix, including the longest legal waits
      instr(8'h01, 1'b0, 0, 0);
      instr(8'h02, 1'b0, 0, 3);
      instr(8'h05, 1'b0, 0, 0);
      instr(8'h05, 1'b1, 0, 0);
      instr(8'h04, 1'b0, 1, 0);
      instr(8'h03, 1'b0, 1, 2);
      instr(8'h77, 1'b1, 0, 0);
      instr(8'h01, 1'b0, T - 1, T - 1);
      play();

      // random program
      for (int i = 0; i < 250; i++) instr(rand_op(), rb(), rand_wait(), rand_wait());
      play();

      // fetch timeout
      do_reset();
      start();
      instr(8'h00, 1'b0, 0, 0);
      instr(8'h01, 1'b0, T + 4, 0);
      play();

      // memory-phase timeout
      do_reset();
      start();
      instr(8'h03, 1'b1, 2, T);
      play();

      // explicit halt keeps bus_err clear
      do_reset();
      start();
      instr(8'h00, 1'b0, 0, 0);
      instr(8'hFF, 1'b0, 1, 0);
      instr(8'h00, 1'b0, 0, 0);
      play();

      // reset in the middle of a store
      do_reset();
      start();
      instr(8'h01, 1'b0, 0, 0);
      push(rb(), 8'h02, 1'b0, PCV | MAR);
      push(1'b1, 8'h02, 1'b0, MEMV | IRL | PCI);
      push(rb(), 8'h02, 1'b0, 12'h000);
      push(rb(), 8'h02, 1'b0, IRV | MAR);
      push(1'b0, 8'h02, 1'b0, ACCV | MW);
      push(1'b0, 8'h02, 1'b0, ACCV | MW);
      play();
      do_reset();

      // back to normal operation after the mid-access reset
      start();
      instr(8'h02, 1'b0, 0, 1);
      instr(8'h00, 1'b0, 0, 0);
      play();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
